// File: rtl/uart_rx_dma_ctrl.sv
// UART receive DMA channel: buffers received bytes in a small FIFO and
// writes them one byte per grant into blockram, sharing the write port with the CPU.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   cfg_write/addr/wdata    CPU register write (0 DST, 1 LEN, 2 CTRL, 3 COUNT)
//   cfg_rdata               combinational register read
//   rx_valid, rx_data       received byte strobe and data
//   cpu_mem_req, cpu_stall  CPU port request / hold while DMA owns the port
//   ram_we/be/addr/wdata    DMA blockram write port
//   irq_done                one-cycle transfer-complete pulse
module uart_rx_dma_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_write,
   input  logic [1:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   output logic [31:0] cfg_rdata,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        cpu_mem_req,
   output logic        cpu_stall,
   output logic        ram_we,
   output logic [3:0]  ram_be,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic        irq_done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [7:0] SMAX = 8'(STARVE_MAX);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic [31:0] dst;
   logic [31:0] ptr;
   logic [15:0] len;
   logic [15:0] rem;
   logic [15:0] count;
   logic        done;
   logic        ovf;
   logic        irq_q;
   logic [7:0]  starve_cnt;
   logic [7:0]  mem [FIFO_DEPTH];
   // extra MSB distinguishes full from empty
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   logic ctrl_wr;
   logic start;
   logic abort;
   logic empty;
   logic full;
   logic want;
   logic grant;
   logic push;

   always_comb begin
      ctrl_wr = cfg_write && (cfg_addr == 2'd2);
      start   = ctrl_wr && cfg_wdata[0] && (state == IDLE);
      abort   = ctrl_wr && !cfg_wdata[0] && (state == RUN);
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
             && (wr_ptr[AW] != rd_ptr[AW]);
      want    = (state == RUN) && !empty;
      // an abort in the same cycle suppresses the write
      grant   = want && !abort
             && (!cpu_mem_req || (starve_cnt == SMAX));
      push    = (state == RUN) && rx_valid && !full;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         dst        <= '0;
         len        <= '0;
         ptr        <= '0;
         rem        <= '0;
         count      <= '0;
         done       <= 1'b0;
         ovf        <= 1'b0;
         irq_q      <= 1'b0;
         starve_cnt <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         irq_q <= 1'b0;

         if (cfg_write && (cfg_addr == 2'd0)) dst <= cfg_wdata;
         if (cfg_write && (cfg_addr == 2'd1)) len <= cfg_wdata[15:0];
         if (ctrl_wr && cfg_wdata[1]) done <= 1'b0;
         if (ctrl_wr && cfg_wdata[2]) ovf  <= 1'b0;

         if (start) begin
            state  <= RUN;
            ptr    <= dst;
            rem    <= len;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else if (abort) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else if (state == RUN) begin
            if (push) begin
               mem[wr_ptr[AW-1:0]] <= rx_data;
               wr_ptr <= wr_ptr + 1'b1;
            end
            // set after the W1C above so a same-cycle set wins
            if (rx_valid && full) ovf <= 1'b1;
            if (grant) begin
               rd_ptr <= rd_ptr + 1'b1;
               ptr    <= ptr + 32'd1;
               rem    <= rem - 16'd1;
               count  <= count + 16'd1;
               if (rem == 16'd1) begin
                  state <= IDLE;
                  done  <= 1'b1;
                  irq_q <= 1'b1;
               end
            end else if (rem == 16'd0) begin
               state <= IDLE;
               done  <= 1'b1;
               irq_q <= 1'b1;
            end
         end

         if (!want || grant) starve_cnt <= '0;
         else if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
      end
   end

   always_comb begin
      ram_we    = grant;
      cpu_stall = grant && cpu_mem_req;
      ram_addr  = ptr;
      ram_be    = 4'b0001 << ptr[1:0];
      ram_wdata = {4{mem[rd_ptr[AW-1:0]]}};
      irq_done  = irq_q;
   end

   always_comb begin
      unique case (cfg_addr)
         2'd0:    cfg_rdata = dst;
         2'd1:    cfg_rdata = {16'd0, len};
         2'd2:    cfg_rdata = {29'd0, ovf, done, state == RUN};
         default: cfg_rdata = {16'd0, count};
      endcase
   end
endmodule
